// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one partial product per clock,
// signed or unsigned per operation, with valid/ready handshakes on input and output.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_next;
    logic [CW-1:0]    count;
    logic             neg;

    // The most negative operand negates to itself, which read as unsigned is the correct magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic is_signed);
        if (is_signed && x[WIDTH-1]) return WIDTH'(-x);
        return x;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag, input logic negate);
        return negate ? PW'(-mag) : mag;
    endfunction

    assign acc_next = mb[0] ? acc + (PW'(ma) << count) : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            prod      <= '0;
            acc       <= '0;
            ma        <= '0;
            mb        <= '0;
            count     <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ma       <= magnitude(a, sign);
                        mb       <= magnitude(b, sign);
                        neg      <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc      <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                // No early exit on zero operands: latency stays data-independent.
                BUSY: begin
                    acc   <= acc_next;
                    mb    <= mb >> 1;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        prod      <= apply_sign(acc_next, neg);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: WIDTH=8 and WIDTH=16 instances, transaction-level model checked every
// cycle, plus hand-computed literal products checked at each output handshake.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, sign8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;
    logic        in_valid16, in_ready16, sign16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .sign(sign8), .out_valid(out_valid8), .out_ready(out_ready8), .prod(prod8));

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
        .sign(sign16), .out_valid(out_valid16), .out_ready(out_ready16), .prod(prod16));

    // Per-instance views (index 0: WIDTH=8, index 1: WIDTH=16)
    logic        iv[2], rdy[2], sg[2], ov[2], ordy[2];
    logic [15:0] av[2], bv[2];
    logic [31:0] pv[2];
    always_comb begin
        iv[0] = in_valid8;  rdy[0] = in_ready8;  sg[0] = sign8;  ov[0] = out_valid8;  ordy[0] = out_ready8;
        av[0] = {8'b0, a8}; bv[0] = {8'b0, b8};  pv[0] = {16'b0, prod8};
        iv[1] = in_valid16; rdy[1] = in_ready16; sg[1] = sign16; ov[1] = out_valid16; ordy[1] = out_ready16;
        av[1] = a16;        bv[1] = b16;         pv[1] = prod16;
    end

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] lit8[$];
    logic [31:0] lit16[$];

    function automatic int wd(int i);
        return (i == 0) ? 8 : 16;
    endfunction

    function automatic logic [31:0] model_prod(int w, logic [15:0] x, logic [15:0] y, logic s);
        longint sx, sy, p;
        sx = longint'(x);
        sy = longint'(y);
        if (s && x[w-1]) sx = sx - (longint'(1) << w);
        if (s && y[w-1]) sy = sy - (longint'(1) << w);
        p = sx * sy;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Transaction model: accept when ready, result visible WIDTH edges later, held until taken.
    logic        m_rdy[2], m_ov[2], m_busy[2], m_hs[2];
    int          m_cnt[2];
    logic [31:0] m_pend[2], m_prod[2], m_hs_prod[2];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_rdy[i] <= 1'b1; m_ov[i] <= 1'b0; m_busy[i] <= 1'b0; m_hs[i] <= 1'b0;
                m_cnt[i] <= 0;    m_pend[i] <= '0; m_prod[i] <= '0;   m_hs_prod[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_hs[i]      <= m_ov[i] && ordy[i];
                m_hs_prod[i] <= pv[i];
                if (m_rdy[i] && iv[i]) begin
                    m_rdy[i]  <= 1'b0;
                    m_busy[i] <= 1'b1;
                    m_cnt[i]  <= 0;
                    m_pend[i] <= model_prod(wd(i), av[i], bv[i], sg[i]);
                end else if (m_busy[i]) begin
                    m_cnt[i] <= m_cnt[i] + 1;
                    if (m_cnt[i] + 1 == wd(i)) begin
                        m_busy[i] <= 1'b0;
                        m_ov[i]   <= 1'b1;
                        m_prod[i] <= m_pend[i];
                    end
                end else if (m_ov[i] && ordy[i]) begin
                    m_ov[i]  <= 1'b0;
                    m_rdy[i] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                logic [31:0] lit;
                vectors++;
                if (rdy[i] !== m_rdy[i] || ov[i] !== m_ov[i] || pv[i] !== m_prod[i]) begin
                    miscompares++;
                    $display("FAIL cycle_outputs w=%0d t=%0t: actual in_ready=%b out_valid=%b prod=%h, required in_ready=%b out_valid=%b prod=%h",
                             wd(i), $time, rdy[i], ov[i], pv[i], m_rdy[i], m_ov[i], m_prod[i]);
                end
                if (m_hs[i]) begin
                    vectors++;
                    if ((i == 0 && lit8.size() == 0) || (i == 1 && lit16.size() == 0)) begin
                        miscompares++;
                        $display("FAIL unexpected_result w=%0d t=%0t: actual prod=%h, required no result", wd(i), $time, m_hs_prod[i]);
                    end else begin
                        if (i == 0) lit = lit8.pop_front();
                        else        lit = lit16.pop_front();
                        if (m_hs_prod[i] !== lit) begin
                            miscompares++;
                            $display("FAIL literal_prod w=%0d t=%0t: actual %h, required %h", wd(i), $time, m_hs_prod[i], lit);
                        end
                    end
                end
            end
        end
    end

    task automatic set_in(int i, logic v, logic [15:0] x, logic [15:0] y, logic s);
        if (i == 0) begin in_valid8 = v;  a8 = x[7:0]; b8 = y[7:0]; sign8 = s;  end
        else        begin in_valid16 = v; a16 = x;     b16 = y;     sign16 = s; end
    endtask

    task automatic set_or(int i, logic v);
        if (i == 0) out_ready8 = v;
        else        out_ready16 = v;
    endtask

    task automatic wait_ready(int i);
        bit ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = rdy[i];
        end
        if (!ok) begin
            $display("FAIL accept_timeout w=%0d: actual in_ready=0, required 1 within 100 cycles", wd(i));
            $fatal(1, "bench stopped");
        end
    endtask

    task automatic wait_valid(int i);
        bit ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = ov[i];
        end
        if (!ok) begin
            $display("FAIL result_timeout w=%0d: actual out_valid=0, required 1 within 100 cycles", wd(i));
            $fatal(1, "bench stopped");
        end
    endtask

    task automatic push_lit(int i, logic [31:0] lit);
        if (i == 0) lit8.push_back(lit);
        else        lit16.push_back(lit);
    endtask

    // One operation: issue, scramble operands while busy, hold back the result 'hold' cycles.
    task automatic run_op(int i, logic [15:0] x, logic [15:0] y, logic s, logic [31:0] lit, int hold);
        push_lit(i, lit);
        wait_ready(i);
        #2 set_in(i, 1'b1, x, y, s);
        @(posedge clk);
        #1 set_in(i, 1'b0, ~x, ~y, ~s);
        wait_valid(i);
        repeat (hold) @(negedge clk);
        #2 set_or(i, 1'b1);
        @(posedge clk);
        #1 set_or(i, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 1'b0, '0, '0, 1'b0);
        set_in(1, 1'b0, '0, '0, 1'b0);
        set_or(0, 1'b0);
        set_or(1, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // WIDTH=8 signed and unsigned products, corners, zero operands
        run_op(0, 16'd42,   16'd7,    1'b1, 32'h0000_0126, 3);
        run_op(0, 16'hD6,   16'd7,    1'b1, 32'h0000_FEDA, 0);
        run_op(0, 16'd7,    16'hD6,   1'b1, 32'h0000_FEDA, 0);
        run_op(0, 16'hD6,   16'hD6,   1'b1, 32'h0000_06E4, 0);
        run_op(0, 16'h80,   16'h80,   1'b1, 32'h0000_4000, 0);
        run_op(0, 16'h80,   16'h7F,   1'b1, 32'h0000_C080, 0);
        run_op(0, 16'hFF,   16'hFF,   1'b0, 32'h0000_FE01, 0);
        run_op(0, 16'h00,   16'h5A,   1'b0, 32'h0000_0000, 0);
        run_op(0, 16'h00,   16'hFF,   1'b1, 32'h0000_0000, 0);
        // backpressure: result held for 5 cycles
        run_op(0, 16'd13,   16'd11,   1'b0, 32'h0000_008F, 5);

        // back-to-back with in_valid held high and out_ready held high
        push_lit(0, 32'd1);
        push_lit(0, 32'd120);
        #2 set_or(0, 1'b1);
        wait_ready(0);
        #2 set_in(0, 1'b1, 16'd1, 16'd1, 1'b0);
        @(posedge clk);
        #1 set_in(0, 1'b1, 16'd10, 16'd12, 1'b0);
        @(negedge clk);
        wait_ready(0);
        @(posedge clk);
        #1 set_in(0, 1'b0, '0, '0, 1'b0);
        wait_valid(0);
        @(posedge clk);
        #1 set_or(0, 1'b0);

        // reset during the third BUSY cycle discards the operation
        wait_ready(0);
        #2 set_in(0, 1'b1, 16'd100, 16'd100, 1'b0);
        @(posedge clk);
        #1 set_in(0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        run_op(0, 16'hFF,   16'hFF,   1'b1, 32'h0000_0001, 0);

        // WIDTH=16
        run_op(1, 16'd42,   16'd7,    1'b1, 32'h0000_0126, 1);
        run_op(1, 16'hFFD6, 16'd7,    1'b1, 32'hFFFF_FEDA, 0);
        run_op(1, 16'hFFD6, 16'hFFD6, 1'b1, 32'h0000_06E4, 0);
        run_op(1, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 0);
        run_op(1, 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000, 0);
        run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 0);
        run_op(1, 16'h0000, 16'h1234, 1'b1, 32'h0000_0000, 2);

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
